ili9341_spi_responder: RTL and testbench

- SPI-peripheral model of the ILI9341 panel: the receiving end of the display controller's SPI command/pixel stream.
- Deserializes 8-bit SPI mode-0 traffic qualified by data_commandb, and decodes CASET, PASET and RAMWR.
- Emits addressed pixel writes toward a framebuffer or scoreboard.
- Used in simulation and in FPGA loopback tests to check the display controller without a physical panel.

---
 rtl/ili9341_spi_responder.sv | 194 +++++++++++++++++++
 tb/tb_ili9341_spi_responder.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ili9341_spi_responder.sv
// ILI9341 SPI responder: deserializes SPI mode-0 bytes, decodes CASET/PASET/RAMWR
// and emits addressed RGB565 pixel writes.
// Ports:
//   clk, rstb                 system clock (>= 4x spi_clk), async active-low reset
//   spi_csb, spi_clk,
//   spi_mosi, data_commandb   raw SPI inputs (asynchronous to clk)
//   cmd_valid, cmd            one-cycle pulse and value of each command byte
//   px_valid, px_x, px_y,
//   px_color                  one-cycle pixel write with coordinates and colour
//   frame_done                pulses with the pixel that closes the window
module ili9341_spi_responder #(
    parameter int DISPLAY_WIDTH  = 240,
    parameter int DISPLAY_HEIGHT = 320
) (
    input  logic                              clk,
    input  logic                              rstb,
    input  logic                              spi_csb,
    input  logic                              spi_clk,
    input  logic                              spi_mosi,
    input  logic                              data_commandb,
    output logic                              cmd_valid,
    output logic [7:0]                        cmd,
    output logic                              px_valid,
    output logic [$clog2(DISPLAY_WIDTH)-1:0]  px_x,
    output logic [$clog2(DISPLAY_HEIGHT)-1:0] px_y,
    output logic [15:0]                       px_color,
    output logic                              frame_done
);

    localparam int unsigned XW = $clog2(DISPLAY_WIDTH);
    localparam int unsigned YW = $clog2(DISPLAY_HEIGHT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CASET,
        S_PASET,
        S_RAMWR
    } state_t;

    // Two-flop synchronizers plus one delayed copy of clk/csb for edge detection
    logic [1:0] csb_sync, sclk_sync, mosi_sync, dc_sync;
    logic       sclk_d, csb_d;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            csb_sync  <= 2'b11;
            sclk_sync <= 2'b00;
            mosi_sync <= 2'b00;
            dc_sync   <= 2'b00;
            sclk_d    <= 1'b0;
            csb_d     <= 1'b1;
        end else begin
            csb_sync  <= {csb_sync[0], spi_csb};
            sclk_sync <= {sclk_sync[0], spi_clk};
            mosi_sync <= {mosi_sync[0], spi_mosi};
            dc_sync   <= {dc_sync[0], data_commandb};
            sclk_d    <= sclk_sync[1];
            csb_d     <= csb_sync[1];
        end
    end

    logic csb_s, sclk_s, mosi_s, dc_s;
    assign csb_s  = csb_sync[1];
    assign sclk_s = sclk_sync[1];
    assign mosi_s = mosi_sync[1];
    assign dc_s   = dc_sync[1];

    // An edge counts if csb was low in this or the previous synced cycle, so a
    // csb release that lands together with the final edge still keeps the byte.
    logic sclk_rise_c;
    assign sclk_rise_c = sclk_s && !sclk_d && !(csb_s && csb_d);

    logic [6:0] shift;
    logic [2:0] bit_cnt;
    logic       byte_done_c;
    logic [7:0] rx_byte_c;
    assign byte_done_c = sclk_rise_c && (bit_cnt == 3'd7);
    assign rx_byte_c   = {shift, mosi_s};

    // Bit shifter; csb high drops any partial byte
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            shift   <= '0;
            bit_cnt <= '0;
        end else if (sclk_rise_c) begin
            shift   <= {shift[5:0], mosi_s};
            bit_cnt <= csb_s ? 3'd0 : bit_cnt + 3'd1;
        end else if (csb_s) begin
            bit_cnt <= '0;
        end
    end

    state_t      state;
    logic [1:0]  par_cnt;
    logic [23:0] par;
    logic [15:0] sc, ec, sp, ep;
    logic [15:0] ptr_x, ptr_y;
    logic        hi_phase;
    logic [7:0]  color_hi;
    logic        win_bad;

    logic x_last_c, y_last_c;
    assign x_last_c = !(ptr_x < ec);
    assign y_last_c = !(ptr_y < ep);

    // Command decoder, window registers and pixel pointer
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state      <= S_IDLE;
            par_cnt    <= '0;
            par        <= '0;
            sc         <= '0;
            ec         <= 16'(DISPLAY_WIDTH - 1);
            sp         <= '0;
            ep         <= 16'(DISPLAY_HEIGHT - 1);
            ptr_x      <= '0;
            ptr_y      <= '0;
            hi_phase   <= 1'b1;
            color_hi   <= '0;
            win_bad    <= 1'b0;
            cmd_valid  <= 1'b0;
            cmd        <= '0;
            px_valid   <= 1'b0;
            px_x       <= '0;
            px_y       <= '0;
            px_color   <= '0;
            frame_done <= 1'b0;
        end else begin
            cmd_valid  <= 1'b0;
            px_valid   <= 1'b0;
            frame_done <= 1'b0;
            if (byte_done_c) begin
                if (!dc_s) begin
                    cmd_valid <= 1'b1;
                    cmd       <= rx_byte_c;
                    par_cnt   <= '0;
                    hi_phase  <= 1'b1;
                    case (rx_byte_c)
                        8'h2A:   state <= S_CASET;
                        8'h2B:   state <= S_PASET;
                        8'h2C: begin
                            state   <= S_RAMWR;
                            ptr_x   <= sc;
                            ptr_y   <= sp;
                            win_bad <= (sc > ec) || (sp > ep) ||
                                       (ec >= 16'(DISPLAY_WIDTH)) ||
                                       (ep >= 16'(DISPLAY_HEIGHT));
                        end
                        default: state <= S_IDLE;
                    endcase
                end else begin
                    case (state)
                        S_CASET, S_PASET: begin
                            if (par_cnt == 2'd3) begin
                                // All four parameter bytes land together
                                if (state == S_CASET) {sc, ec} <= {par, rx_byte_c};
                                else                  {sp, ep} <= {par, rx_byte_c};
                                state   <= S_IDLE;
                                par_cnt <= '0;
                            end else begin
                                par     <= {par[15:0], rx_byte_c};
                                par_cnt <= par_cnt + 2'd1;
                            end
                        end
                        S_RAMWR: begin
                            if (hi_phase) begin
                                color_hi <= rx_byte_c;
                                hi_phase <= 1'b0;
                            end else begin
                                hi_phase <= 1'b1;
                                if (!win_bad) begin
                                    px_valid   <= 1'b1;
                                    px_x       <= ptr_x[XW-1:0];
                                    px_y       <= ptr_y[YW-1:0];
                                    px_color   <= {color_hi, rx_byte_c};
                                    frame_done <= x_last_c && y_last_c;
                                end
                                // Raster advance within the window, wrapping forever
                                if (!x_last_c) begin
                                    ptr_x <= ptr_x + 16'd1;
                                end else begin
                                    ptr_x <= sc;
                                    ptr_y <= y_last_c ? sp : ptr_y + 16'd1;
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_ili9341_spi_responder.sv
// Self-checking bench for ili9341_spi_responder: directed and randomized SPI
// traffic against a window/pixel-index reference model.
module tb_ili9341_spi_responder;

    localparam int W    = 240;
    localparam int H    = 320;
    localparam int HALF = 50;

    logic       clk = 1'b0;
    logic       rstb = 1'b0;
    logic       spi_csb = 1'b1;
    logic       spi_clk = 1'b0;
    logic       spi_mosi = 1'b0;
    logic       data_commandb = 1'b0;
    logic       cmd_valid;
    logic [7:0] cmd;
    logic       px_valid;
    logic [7:0] px_x;
    logic [8:0] px_y;
    logic [15:0] px_color;
    logic       frame_done;

    ili9341_spi_responder #(.DISPLAY_WIDTH(W), .DISPLAY_HEIGHT(H)) dut (
        .clk(clk), .rstb(rstb), .spi_csb(spi_csb), .spi_clk(spi_clk),
        .spi_mosi(spi_mosi), .data_commandb(data_commandb),
        .cmd_valid(cmd_valid), .cmd(cmd), .px_valid(px_valid), .px_x(px_x),
        .px_y(px_y), .px_color(px_color), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Observed event streams
    logic [7:0]  obs_cmd[$];
    logic [48:0] obs_px[$];
    int          stray_fd = 0;

    always @(negedge clk) begin
        if (rstb) begin
            if (cmd_valid) obs_cmd.push_back(cmd);
            if (px_valid) obs_px.push_back({frame_done, 16'(px_x), 16'(px_y), px_color});
            else if (frame_done) stray_fd++;
        end
    end

    // Reference model: window plus a running pixel index inside the current RAMWR
    logic [7:0]  exp_cmd[$];
    logic [48:0] exp_px[$];
    int m_sc, m_ec, m_sp, m_ep, m_mode, m_pcnt, m_npix;
    int m_par[4];
    bit m_hi, m_bad;
    logic [7:0] m_chi;

    function automatic void model_reset();
        m_sc = 0; m_ec = W - 1; m_sp = 0; m_ep = H - 1;
        m_mode = 0; m_pcnt = 0; m_npix = 0; m_hi = 1'b1; m_bad = 1'b0;
    endfunction

    function automatic void model_byte(input logic dc, input logic [7:0] b);
        int w, h, x, y;
        bit fd;
        if (!dc) begin
            exp_cmd.push_back(b);
            m_pcnt = 0;
            m_hi   = 1'b1;
            m_mode = (b == 8'h2A) ? 1 : (b == 8'h2B) ? 2 : (b == 8'h2C) ? 3 : 0;
            if (m_mode == 3) begin
                m_npix = 0;
                m_bad  = (m_sc > m_ec) || (m_sp > m_ep) || (m_ec >= W) || (m_ep >= H);
            end
        end else if (m_mode == 1 || m_mode == 2) begin
            m_par[m_pcnt] = int'(b);
            m_pcnt++;
            if (m_pcnt == 4) begin
                if (m_mode == 1) begin
                    m_sc = m_par[0] * 256 + m_par[1];
                    m_ec = m_par[2] * 256 + m_par[3];
                end else begin
                    m_sp = m_par[0] * 256 + m_par[1];
                    m_ep = m_par[2] * 256 + m_par[3];
                end
                m_mode = 0;
                m_pcnt = 0;
            end
        end else if (m_mode == 3) begin
            if (m_hi) begin
                m_chi = b;
                m_hi  = 1'b0;
            end else begin
                m_hi = 1'b1;
                if (!m_bad) begin
                    w  = m_ec - m_sc + 1;
                    h  = m_ep - m_sp + 1;
                    x  = m_sc + m_npix % w;
                    y  = m_sp + (m_npix / w) % h;
                    fd = (m_npix % (w * h)) == (w * h - 1);
                    exp_px.push_back({fd, 16'(x), 16'(y), m_chi, b});
                end
                m_npix++;
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic spi_byte(input logic dc, input logic [7:0] b);
        data_commandb = dc;
        spi_csb = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            spi_mosi = b[i];
            #HALF spi_clk = 1'b1;
            #HALF spi_clk = 1'b0;
        end
        model_byte(dc, b);
    endtask

    task automatic send_window(input logic [7:0] c, input int s, input int e);
        spi_byte(1'b0, c);
        spi_byte(1'b1, 8'(s >> 8));
        spi_byte(1'b1, 8'(s));
        spi_byte(1'b1, 8'(e >> 8));
        spi_byte(1'b1, 8'(e));
    endtask

    task automatic send_pixels(input int n);
        logic [15:0] c;
        for (int i = 0; i < n; i++) begin
            c = 16'($urandom);
            spi_byte(1'b1, c[15:8]);
            spi_byte(1'b1, c[7:0]);
        end
    endtask

    // Let the last byte reach the outputs, then compare and clear both streams
    task automatic compare_step(input string tag);
        int n;
        repeat (10) @(posedge clk);
        chk({tag, " cmd count"}, 64'(obs_cmd.size()), 64'(exp_cmd.size()));
        n = (obs_cmd.size() < exp_cmd.size()) ? obs_cmd.size() : exp_cmd.size();
        for (int i = 0; i < n; i++) chk({tag, " cmd"}, 64'(obs_cmd[i]), 64'(exp_cmd[i]));
        chk({tag, " px count"}, 64'(obs_px.size()), 64'(exp_px.size()));
        n = (obs_px.size() < exp_px.size()) ? obs_px.size() : exp_px.size();
        for (int i = 0; i < n; i++) chk({tag, " px {fd,x,y,color}"}, 64'(obs_px[i]), 64'(exp_px[i]));
        obs_cmd.delete(); exp_cmd.delete(); obs_px.delete(); exp_px.delete();
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, " cmd_valid"}, 64'(cmd_valid), 64'd0);
        chk({tag, " cmd"}, 64'(cmd), 64'd0);
        chk({tag, " px_valid"}, 64'(px_valid), 64'd0);
        chk({tag, " px_x"}, 64'(px_x), 64'd0);
        chk({tag, " px_y"}, 64'(px_y), 64'd0);
        chk({tag, " px_color"}, 64'(px_color), 64'd0);
        chk({tag, " frame_done"}, 64'(frame_done), 64'd0);
    endtask

    initial begin
        int sc, sp, w, h;
        model_reset();
        #1;
        chk_outputs_zero("reset");
        repeat (3) @(negedge clk);
        rstb = 1'b1;
        repeat (3) @(negedge clk);

        // Default window, two known pixels
        spi_byte(1'b0, 8'h2C);
        spi_byte(1'b1, 8'h12); spi_byte(1'b1, 8'h34);
        spi_byte(1'b1, 8'h56); spi_byte(1'b1, 8'h78);
        compare_step("default ramwr");

        // 3x2 window, seven pixels: frame_done on the sixth, seventh wraps
        send_window(8'h2A, 10, 12);
        send_window(8'h2B, 20, 21);
        spi_byte(1'b0, 8'h2C);
        send_pixels(7);
        compare_step("window 3x2");

        // Partial byte dropped by a csb pulse
        spi_csb = 1'b0;
        for (int i = 0; i < 5; i++) begin
            spi_mosi = 1'(i);
            #HALF spi_clk = 1'b1;
            #HALF spi_clk = 1'b0;
        end
        spi_csb = 1'b1;
        #200;
        spi_byte(1'b0, 8'h2C);
        compare_step("csb abort");

        // Unknown command with data leaves the window alone
        spi_byte(1'b0, 8'hB1);
        send_pixels(1);
        spi_byte(1'b1, 8'hAA);
        compare_step("unknown cmd");
        spi_byte(1'b0, 8'h2C);
        send_pixels(1);
        compare_step("window kept");

        // Inverted column range suppresses pixels
        send_window(8'h2A, 20, 10);
        spi_byte(1'b0, 8'h2C);
        send_pixels(2);
        compare_step("invalid window");

        // Truncated CASET keeps the previous window
        send_window(8'h2A, 10, 12);
        spi_byte(1'b0, 8'h2A);
        spi_byte(1'b1, 8'h00); spi_byte(1'b1, 8'h05);
        spi_byte(1'b0, 8'h2C);
        send_pixels(2);
        compare_step("short caset");

        // Randomized small windows with wraparound
        for (int k = 0; k < 3; k++) begin
            sc = $urandom_range(0, 230); w = $urandom_range(1, 4);
            sp = $urandom_range(0, 310); h = $urandom_range(1, 3);
            send_window(8'h2A, sc, sc + w - 1);
            send_window(8'h2B, sp, sp + h - 1);
            spi_byte(1'b0, 8'h2C);
            send_pixels(w * h + $urandom_range(1, w * h));
            compare_step("random window");
        end

        // Reset in the middle of a pixel
        spi_byte(1'b0, 8'h2C);
        spi_byte(1'b1, 8'h9A);
        compare_step("pre-reset");
        @(negedge clk);
        rstb = 1'b0;
        #1;
        chk_outputs_zero("mid reset");
        model_reset();
        exp_cmd.delete(); exp_px.delete();
        repeat (3) @(negedge clk);
        rstb = 1'b1;
        repeat (3) @(negedge clk);
        spi_byte(1'b1, 8'hBC);
        compare_step("after reset lone byte");
        spi_byte(1'b0, 8'h2C);
        send_pixels(2);
        compare_step("after reset default window");

        chk("stray frame_done", 64'(stray_fd), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
